// File: rtl/fifo_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: default geometry,
// FSM state encodings and a small helper used to gate request handling.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000,
        ST_ERROR  = 4'b0000
    } state_e;

    // Push/pop are only serviced once thresholds are latched; ERROR keeps servicing.
    function automatic logic req_enabled(input state_e st);
        return (st == ST_IDLE) || (st == ST_ACTIVE) || (st == ST_ERROR);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer: advances by one when inc_i is high and
// wraps naturally from the last address back to zero.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    // Next pointer value
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving the write and read ports of a dual-port RAM:
// request arbitration, occupancy, status flags, read-data return and FSM.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CNT_WIDTH-1:0]  thr_high,
    input  logic [CNT_WIDTH-1:0]  thr_low,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [3:0]            state,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [ADDR_WIDTH-1:0] addr_wa,
    output logic [ADDR_WIDTH-1:0] addr_ra,
    output logic                  we_a,
    output logic                  re_a,
    input  logic [DATA_WIDTH-1:0] q_a
);

    localparam int FIFO_DEPTH = (ADDR_WIDTH == DEF_ADDR_WIDTH) ? DEPTH : (1 << ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

    state_e                state_q;
    state_e                state_d;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  count_d;
    logic [CNT_WIDTH-1:0]  thr_high_q;
    logic [CNT_WIDTH-1:0]  thr_high_d;
    logic [CNT_WIDTH-1:0]  thr_low_q;
    logic [CNT_WIDTH-1:0]  thr_low_d;
    logic                  error_q;
    logic                  error_d;
    logic                  rd_pend_q;
    logic                  rd_pend_d;
    logic [DATA_WIDTH-1:0] data_hold_q;
    logic [DATA_WIDTH-1:0] data_hold_d;

    logic                  req_en_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_acc_s;
    logic                  pop_acc_s;
    logic                  overflow_s;
    logic                  underflow_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_s;

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc_i   (push_acc_s),
        .ptr_o   (wr_ptr_s)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk     (clk),
        .reset_L (reset_L),
        .inc_i   (pop_acc_s),
        .ptr_o   (rd_ptr_s)
    );

    // Request acceptance; a pop frees the slot a same-cycle push on full needs
    always_comb begin
        req_en_s    = reset_L & req_enabled(state_q);
        full_s      = (count_q == FULL_CNT);
        empty_s     = (count_q == '0);
        pop_acc_s   = req_en_s & pop & ~empty_s;
        push_acc_s  = req_en_s & push & (~full_s | pop_acc_s);
        overflow_s  = req_en_s & push & ~push_acc_s;
        underflow_s = req_en_s & pop & empty_s;
    end

    // RAM port drive, presented in the same cycle as the accepted request
    always_comb begin
        we_a    = push_acc_s;
        re_a    = pop_acc_s;
        addr_wa = wr_ptr_s;
        addr_ra = rd_ptr_s;
        if (push_acc_s) begin
            data_a = data_in;
        end else begin
            data_a = '0;
        end
    end

    // Occupancy, threshold latch, sticky error and read-return bookkeeping
    always_comb begin
        count_d     = count_q + CNT_WIDTH'(push_acc_s) - CNT_WIDTH'(pop_acc_s);
        error_d     = error_q | overflow_s | underflow_s;
        rd_pend_d   = pop_acc_s;
        thr_high_d  = thr_high_q;
        thr_low_d   = thr_low_q;
        data_hold_d = data_hold_q;
        if (state_q == ST_INIT) begin
            thr_high_d = thr_high;
            thr_low_d  = thr_low;
        end else begin
            thr_high_d = thr_high_q;
            thr_low_d  = thr_low_q;
        end
        if (rd_pend_q) begin
            data_hold_d = q_a;
        end else begin
            data_hold_d = data_hold_q;
        end
    end

    // FSM next-state; ACTIVE falls back to IDLE once the FIFO drains with no push
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE: begin
                if (overflow_s || underflow_s) begin
                    state_d = ST_ERROR;
                end else if (push_acc_s) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (overflow_s || underflow_s) begin
                    state_d = ST_ERROR;
                end else if ((count_d == '0) && !push) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q     <= ST_RESET;
            count_q     <= '0;
            thr_high_q  <= '0;
            thr_low_q   <= '0;
            error_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            thr_high_q  <= thr_high_d;
            thr_low_q   <= thr_low_d;
            error_q     <= error_d;
            rd_pend_q   <= rd_pend_d;
            data_hold_q <= data_hold_d;
        end
    end

    // RAM output is already registered, so read data is forwarded directly
    always_comb begin
        valid_out    = rd_pend_q;
        if (rd_pend_q) begin
            data_out = q_a;
        end else begin
            data_out = data_hold_q;
        end
        full         = full_s;
        empty        = empty_s;
        almost_full  = (count_q >= thr_high_q);
        almost_empty = (count_q <= thr_low_q);
        error        = error_q;
        state        = state_q;
    end

endmodule
